// File: rtl/front_panel_conditioner.sv
// -----------------------------------------------------------------------------
// front_panel_conditioner
//
// Conditions the KIM-1 front-panel controls (ST key, RS key, board KEY and
// the SST switch) before they reach the KIM-1 core. Every raw pin is
// asynchronous, active-low and bouncy. Each pin passes through a two-flop
// synchroniser and then a counter debouncer. From the debounced levels the
// block produces:
//   - a stretched, glitch-free CPU reset (RS or KEY),
//   - a one-shot NMI pulse on each ST press,
//   - a clean SST level and an ST-held diagnostic level.
// No combinational path exists from any raw pin to any output.
//
// Ports:
//   clk        in   1 MHz core clock
//   reset      in   asynchronous, active-high block reset (power-on)
//   st_key_n   in   raw ST key, active low
//   rs_key_n   in   raw RS key, active low
//   key_n      in   raw board KEY, active low (second reset source)
//   sst_n      in   raw SST switch, active low
//   cpu_reset  out  active-high reset to the KIM-1 core
//   nmi        out  active-high NMI pulse, NMI_CYCLES wide
//   sst        out  debounced single-step enable, active high
//   st_held    out  debounced ST level, active high (diagnostic LED)
// -----------------------------------------------------------------------------
module front_panel_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,  // minimum 2
  parameter int RESET_STRETCH   = 16,     // minimum 1
  parameter int NMI_CYCLES      = 4       // minimum 1
) (
  input  logic clk,
  input  logic reset,
  input  logic st_key_n,
  input  logic rs_key_n,
  input  logic key_n,
  input  logic sst_n,
  output logic cpu_reset,
  output logic nmi,
  output logic sst,
  output logic st_held
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RS_W  = $clog2(RESET_STRETCH + 1);
  localparam int NMI_W = $clog2(NMI_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RS_W-1:0]  STRETCH_LAST = RS_W'(RESET_STRETCH - 1);
  localparam logic [NMI_W-1:0] NMI_LAST     = NMI_W'(NMI_CYCLES - 1);

  // Bit positions of the four controls in the packed vectors below.
  localparam int IDX_ST  = 0;
  localparam int IDX_RS  = 1;
  localparam int IDX_KEY = 2;
  localparam int IDX_SST = 3;

  typedef enum logic [1:0] {
    RST_HOLD    = 2'd0,
    RST_STRETCH = 2'd1,
    RST_RUN     = 2'd2
  } rst_state_t;

  logic [3:0] raw_n;
  logic [3:0] sync1_n;
  logic [3:0] sync2_n;
  logic [3:0] stable_n;             // debounced levels, still active low
  logic [DB_W-1:0] db_cnt [4];

  assign raw_n = {sst_n, key_n, rs_key_n, st_key_n};

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Released (high) is the safe reset level.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // samples that disagree with the stable value. One agreeing sample
  // restarts the count, and the load clears the counter, so it never wraps.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_n <= '1;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_n[i] == stable_n[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable_n[i] <= sync2_n[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Clean level outputs, one register after the debounced state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sst     <= 1'b0;
      st_held <= 1'b0;
    end else begin
      sst     <= ~stable_n[IDX_SST];
      st_held <= ~stable_n[IDX_ST];
    end
  end

  // ---------------------------------------------------------------------------
  // Reset FSM: HOLD while either reset source is pressed, then STRETCH for
  // RESET_STRETCH cycles, then RUN. cpu_reset is registered from the next
  // state so it falls on the edge that enters RUN.
  // ---------------------------------------------------------------------------
  rst_state_t      state, next_state;
  logic [RS_W-1:0] stretch_cnt, stretch_cnt_next;
  logic            cpu_reset_next;
  logic            rst_req;

  assign rst_req = ~stable_n[IDX_RS] | ~stable_n[IDX_KEY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RST_STRETCH;
      stretch_cnt <= '0;
      cpu_reset   <= 1'b1;
    end else begin
      state       <= next_state;
      stretch_cnt <= stretch_cnt_next;
      cpu_reset   <= cpu_reset_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    next_state       = state;
    stretch_cnt_next = stretch_cnt;
    unique case (state)
      RST_HOLD: begin
        if (!rst_req) begin
          next_state       = RST_STRETCH;
          stretch_cnt_next = '0;
        end
      end
      RST_STRETCH: begin
        if (rst_req) begin
          next_state       = RST_HOLD;
          stretch_cnt_next = '0;
        end else if (stretch_cnt == STRETCH_LAST) begin
          next_state       = RST_RUN;
          stretch_cnt_next = '0;
        end else begin
          stretch_cnt_next = stretch_cnt + RS_W'(1);
        end
      end
      RST_RUN: begin
        if (rst_req) begin
          next_state       = RST_HOLD;
          stretch_cnt_next = '0;
        end
      end
      default: begin
        next_state       = RST_HOLD;
        stretch_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    cpu_reset_next = (next_state != RST_RUN);
  end

  // ---------------------------------------------------------------------------
  // NMI one-shot. Triggered by a rising edge of debounced ST-pressed. Using
  // the registered cpu_reset discards triggers while reset is asserted,
  // including the cycle it falls, and truncates a pulse one edge after a
  // reset assertion. Triggers during a pulse are simply lost.
  // ---------------------------------------------------------------------------
  logic             st_pressed;
  logic             st_prev;
  logic [NMI_W-1:0] nmi_cnt;

  assign st_pressed = ~stable_n[IDX_ST];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_prev <= 1'b0;
      nmi     <= 1'b0;
      nmi_cnt <= '0;
    end else begin
      st_prev <= st_pressed;
      if (cpu_reset) begin
        nmi     <= 1'b0;
        nmi_cnt <= '0;
      end else if (nmi) begin
        if (nmi_cnt == NMI_LAST) begin
          nmi     <= 1'b0;
          nmi_cnt <= '0;
        end else begin
          nmi_cnt <= nmi_cnt + NMI_W'(1);
        end
      end else if (st_pressed && !st_prev) begin
        nmi     <= 1'b1;
        nmi_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_front_panel_conditioner.sv
// -----------------------------------------------------------------------------
// tb_front_panel_conditioner
//
// Scoreboard bench for front_panel_conditioner with DEBOUNCE_CYCLES=8,
// RESET_STRETCH=4, NMI_CYCLES=2. Inputs change on the falling edge; a
// behavioural model predicts the outputs after the following rising edge and
// queues them; a monitor compares the DUT outputs 1 ns after each rising edge.
//
// Model abstractions:
//   - a debounced level flips when the last DEBOUNCE_CYCLES samples seen by
//     the debouncer (raw pin delayed two edges) all disagree with it;
//   - cpu_reset is low once the reset request has been quiet for more than
//     RESET_STRETCH consecutive edges (async reset counts as one quiet edge);
//   - nmi is a remaining-cycles budget loaded on an ST press.
// Expected vector order: {cpu_reset, nmi, sst, st_held}.
// -----------------------------------------------------------------------------
module tb_front_panel_conditioner;

  localparam int DB = 8;
  localparam int RS = 4;
  localparam int NC = 2;

  // raw vector order: [0]=st, [1]=rs, [2]=key, [3]=sst (active low)
  localparam logic [3:0] IDLE  = 4'b1111;
  localparam logic [3:0] P_ST  = 4'b1110;
  localparam logic [3:0] P_RS  = 4'b1101;
  localparam logic [3:0] P_KEY = 4'b1011;
  localparam logic [3:0] P_SST = 4'b0111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic st_key_n = 1'b1, rs_key_n = 1'b1, key_n = 1'b1, sst_n = 1'b1;
  logic cpu_reset, nmi, sst, st_held;

  always #5 clk = ~clk;

  front_panel_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .RESET_STRETCH  (RS),
    .NMI_CYCLES     (NC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .st_key_n (st_key_n),
    .rs_key_n (rs_key_n),
    .key_n    (key_n),
    .sst_n    (sst_n),
    .cpu_reset(cpu_reset),
    .nmi      (nmi),
    .sst      (sst),
    .st_held  (st_held)
  );

  typedef struct {
    logic [3:0] exp;
    int         phase;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   phase = 0;
  bit   started = 1'b0;

  // Model state
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  int         quiet;
  bit         m_st_prev;
  int         nmi_left;
  bit         m_cpu, m_sst, m_held;

  function automatic string phase_name(input int p);
    case (p)
      0:       return "power_up";
      1:       return "bounce_st";
      2:       return "rs_hold_stretch";
      3:       return "key_repress_stretch";
      4:       return "nmi_suppressed";
      5:       return "async_reset_mid_pulse";
      6:       return "sst_debounce";
      default: return "random";
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got {cpu_reset,nmi,sst,st_held}=%b expected %b", name, got, want);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < DB + 2; k++) hist.push_back(IDLE);
    m_stable  = IDLE;
    quiet     = 1;
    m_st_prev = 1'b0;
    nmi_left  = 0;
    m_cpu     = 1'b1;
    m_sst     = 1'b0;
    m_held    = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] pre;
    bit rst_req, st_p, pre_cpu, all_diff;
    int base;
    pre     = m_stable;
    rst_req = !pre[1] || !pre[2];
    st_p    = !pre[0];
    pre_cpu = m_cpu;

    if (rst_req) quiet = 0;
    else if (quiet < 1000) quiet++;
    m_cpu = (quiet <= RS);

    if (pre_cpu) nmi_left = 0;
    else if (nmi_left > 0) nmi_left--;
    else if (st_p && !m_st_prev) nmi_left = NC;
    m_st_prev = st_p;

    m_sst  = !pre[3];
    m_held = !pre[0];

    hist.push_back(raw);
    if (hist.size() > DB + 4) void'(hist.pop_front());
    // hist[size-1] is this edge's sample; the debouncer sees the one two edges old.
    base = hist.size() - 3;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++)
        if (hist[base - k][i] == pre[i]) all_diff = 1'b0;
      if (all_diff) m_stable[i] = ~pre[i];
    end
  endtask

  // Drive inputs for the next rising edge and queue the predicted outputs.
  task automatic step(input logic [3:0] raw, input bit rst);
    logic [3:0] ev;
    bit was_reset;
    exp_t e;
    @(negedge clk);
    was_reset = reset;
    reset    = rst;
    st_key_n = raw[0];
    rs_key_n = raw[1];
    key_n    = raw[2];
    sst_n    = raw[3];
    if (rst) model_reset();
    else model_edge(raw);
    ev = {m_cpu, (nmi_left > 0), m_sst, m_held};
    e.exp   = ev;
    e.phase = phase;
    e.cyc   = cyc;
    exp_q.push_back(e);
    started = 1'b1;
    cyc++;
    if (rst && !was_reset) begin
      #1;
      check($sformatf("%s immediate async reset cycle %0d", phase_name(phase), cyc),
            {cpu_reset, nmi, sst, st_held}, 4'b1000);
    end
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b0);
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s cycle %0d", phase_name(e.phase), e.cyc),
              {cpu_reset, nmi, sst, st_held}, e.exp);
      end else if (started) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: got empty queue at time %0t, required one entry per edge", $time);
      end
    end
  end

  initial begin
    logic [3:0] cur;
    int         total, bit_sel, r;
    bit         seen;

    // Power-up
    phase = 0;
    model_reset();
    repeat (3) step(IDLE, 1'b1);
    hold(IDLE, 12);

    // Bounce rejection on ST, then a long hold (one pulse only)
    phase = 1;
    hold(P_ST, 5);
    hold(IDLE, 1);
    hold(P_ST, 60);
    hold(IDLE, 20);

    // RS held then released: hold, debounce, stretch
    phase = 2;
    hold(P_RS, 30);
    hold(IDLE, 30);

    // KEY debounced during STRETCH returns to HOLD
    phase = 3;
    hold(P_RS, 15);
    hold(IDLE, 2);
    hold(P_KEY, 20);
    hold(IDLE, 30);

    // ST pressed while reset held: no NMI, not even after reset ends
    phase = 4;
    hold(P_RS, 12);
    hold(P_RS & P_ST, 25);
    hold(P_ST, 30);
    hold(IDLE, 20);

    // Async reset while nmi is high
    phase = 5;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(P_ST, 1'b0);
      if (nmi_left > 0) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL async_reset_mid_pulse: got no nmi pulse within 40 cycles, required one");
    end
    step(P_ST, 1'b1);
    step(IDLE, 1'b1);
    hold(IDLE, 15);

    // SST: 7 low samples rejected, 12 accepted
    phase = 6;
    hold(P_SST, 7);
    hold(IDLE, 20);
    hold(P_SST, 12);
    hold(IDLE, 20);

    // Random segments, one control toggled per segment, occasional async reset
    phase = 7;
    cur   = IDLE;
    total = 0;
    while (total < 1500) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(cur, 1'b1);
        total += 2;
      end else begin
        r = int'($urandom_range(0, 99));
        bit_sel = (r < 40) ? 0 : (r < 70) ? 3 : (r < 85) ? 1 : 2;
        cur[bit_sel] = ~cur[bit_sel];
        // bias the reset sources back to released so the core runs often
        if (!cur[1] && $urandom_range(0, 1) == 0) cur[1] = 1'b1;
        if (!cur[2] && $urandom_range(0, 1) == 0) cur[2] = 1'b1;
        r = int'($urandom_range(1, 14));
        hold(cur, r);
        total += r;
      end
    end
    hold(IDLE, 30);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/front_panel_conditioner.md
Name: front_panel_conditioner

Overview:
- Conditions the KIM-1 front-panel controls before they reach the KIM-1 core: ST key, RS key, board KEY and the SST switch.
- Raw pins are asynchronous, active-low and bouncy. The block synchronises and debounces each one.
- It produces a stretched, glitch-free CPU reset, a one-shot NMI pulse for ST, and a clean SST level.
- It sits between the top-level pins and the KIM_1 core and runs on the 1 MHz core clock.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive stable samples required to accept an input change (20 ms at 1 MHz). Minimum 2.
- RESET_STRETCH, 16, cycles cpu_reset stays high after the reset sources are released.
- NMI_CYCLES, 4, width of the nmi pulse in clk cycles. Minimum 1.

Ports:
- clk  in  1  1 MHz core clock
- reset  in  1  asynchronous, active-high block reset (power-on)
- st_key_n  in  1  raw ST key, active low
- rs_key_n  in  1  raw RS key, active low
- key_n  in  1  raw board KEY, active low, second reset source
- sst_n  in  1  raw SST switch, active low
- cpu_reset  out  1  active-high reset to the KIM-1 core
- nmi  out  1  active-high NMI pulse to the core
- sst  out  1  debounced single-step enable, active high
- st_held  out  1  debounced ST level, active high (diagnostic LED)

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - cpu_reset = 1; nmi = 0; sst = 0; st_held = 0.
  - All synchroniser flops = 1 (released); all debounced states = released; all counters = 0.
  - FSM = STRETCH with stretch counter 0.
- Synchroniser: two flops per input. No combinational path from any raw pin to any output.
- Debouncer, one per input, identical:
  - When the synced value equals the stable value, clear the counter.
  - Otherwise increment the counter.
  - When the counter would reach DEBOUNCE_CYCLES, load the synced value into stable and clear the counter.
  - Any sample equal to stable during counting restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Latency:
  - If the raw pin is first sampled at the new level on edge N, the stable value changes on edge N+1+DEBOUNCE_CYCLES.
  - Registered outputs change one edge later, at N+2+DEBOUNCE_CYCLES.
  - Applies to presses and releases alike.
- sst and st_held are registered copies of the inverted stable values.
- Reset FSM (rst_req = stable RS pressed OR stable KEY pressed):
  - HOLD: cpu_reset=1. When rst_req is 0, go to STRETCH with the counter cleared.
  - STRETCH: cpu_reset=1, counter increments.
    - rst_req=1 → HOLD, counter cleared.
    - Counter reaches RESET_STRETCH-1 → RUN.
    - cpu_reset is therefore high for exactly RESET_STRETCH cycles after entry.
  - RUN: cpu_reset=0. When rst_req=1, go to HOLD.
  - Registered output: cpu_reset falls on the edge after the last STRETCH cycle.
  - RS and KEY both pressed behave as one request. Releasing one keeps HOLD until both are released.
- NMI one-shot:
  - Trigger: rising edge of the stable ST-pressed value, detected against a registered previous copy.
  - On trigger, nmi goes high for exactly NMI_CYCLES cycles.
  - Triggers while nmi is high are ignored (no retrigger, no extension).
  - Triggers while cpu_reset=1 are discarded, including the cycle cpu_reset falls.
  - Holding ST produces exactly one pulse. A new pulse needs a debounced release then a press.
  - A cpu_reset assertion while nmi is high truncates the pulse: nmi=0 on the next edge, counter cleared.
- Async reset mid-operation: all state returns to the reset values immediately. Debouncers restart from released.
- After async reset release with all inputs idle: STRETCH runs RESET_STRETCH cycles, then RUN.

Test Plan (DEBOUNCE_CYCLES=8, RESET_STRETCH=4, NMI_CYCLES=2, all raw inputs high unless stated):
- Power-up: deassert reset → cpu_reset=1 for exactly 4 edges then 0; nmi=0, sst=0, st_held=0 throughout.
- Bounce rejection: st_key_n low 5 cycles, high 1 cycle, then low steady.
  - nmi rises 10 edges after the final low is first sampled and stays high exactly 2 cycles.
  - st_held=1; no second pulse while ST is held for 50 more cycles.
- Reset hold and stretch: rs_key_n low for 30 cycles.
  - cpu_reset=1 from 10 edges after the press.
  - After release, cpu_reset stays 1 through debounce (10) plus stretch (4), then 0.
- Re-press during STRETCH: key_n pressed and debounced during STRETCH → FSM returns to HOLD; stretch restarts from 0 after release.
- NMI suppressed during reset: ST pressed and debounced while rs_key_n is held low → nmi stays 0 throughout and after reset ends.
- Async reset mid-pulse: assert reset while nmi=1 → nmi=0 and cpu_reset=1 immediately.
  - Separately: sst_n low 8+ cycles → sst=1 at the latency above.
  - sst_n low only 7 cycles → sst stays 0.
